// File: rtl/day_to_date_enc.sv
// day_to_date_enc: iterative (year, fractional julian day) to packed YYYYMMDDHH encoder.
// Define DAY_TO_DATE_LEAP400_EN for the full Gregorian leap rule; default is year%4==0.
module day_to_date_enc #(
  parameter int FRAC_W = 8,
  parameter int YEAR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [YEAR_W-1:0]   in_year,
  input  logic [FRAC_W+8:0]   in_jday,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_date,
  output logic                out_err
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ROUND = 3'd1, S_MONTH = 3'd2, S_PACK = 3'd3, S_DONE = 3'd4;
  logic [2:0]        r_state;
  logic [YEAR_W:0]   r_year;
  logic [9:0]        r_day;
  logic [FRAC_W-1:0] r_frac;
  logic [4:0]        r_hour;
  logic [3:0]        r_m;
  logic [31:0]       r_date;
  logic              r_err;
  function automatic logic f_leap(input int y);
`ifdef DAY_TO_DATE_LEAP400_EN
    f_leap = (y[1:0] == 2'd0) && !(y inside {100, 200, 300, 500, 600, 700, 900, 1000, 1100,
                                             1300, 1400, 1500, 1700, 1800, 1900, 2100});
`else
    f_leap = (y[1:0] == 2'd0);
`endif
  endfunction
  function automatic logic [4:0] f_mlen(input logic [3:0] m, input logic leap);
    f_mlen = (m == 4'd2) ? (leap ? 5'd29 : 5'd28) :
             (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  logic [FRAC_W+5:0] w_prod;
  logic [4:0]        w_hr;
  logic              w_carry;
  logic [9:0]        w_yl;
  logic [9:0]        w_d1;
  logic              w_wrap;
  logic [YEAR_W:0]   w_year2;
  logic              w_err;
  logic [4:0]        w_len;
  logic [31:0]       w_pack;
  // hour = round(F*24 / 2^FRAC_W); a full 24 carries into the next day
  assign w_prod  = {6'd0, r_frac} * (FRAC_W+6)'(24) + (FRAC_W+6)'(1 << (FRAC_W-1));
  assign w_hr    = w_prod[FRAC_W+4:FRAC_W];
  assign w_carry = (w_hr == 5'd24);
  assign w_yl    = f_leap(int'(r_year)) ? 10'd366 : 10'd365;
  assign w_d1    = r_day + {9'd0, w_carry};
  assign w_wrap  = (w_d1 > w_yl);
  assign w_year2 = r_year + {{YEAR_W{1'b0}}, w_wrap};
  assign w_err   = (r_day == 10'd0) || (r_day > w_yl) || (w_year2 > (YEAR_W+1)'(2147));
  assign w_len   = f_mlen(r_m, f_leap(int'(r_year)));
  assign w_pack  = 32'(r_year) * 32'd1000000 + 32'(r_m) * 32'd10000 + 32'(r_day) * 32'd100 + 32'(r_hour);
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_date  = r_date;
  assign out_err   = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_year  <= '0;
      r_day   <= '0;
      r_frac  <= '0;
      r_hour  <= '0;
      r_m     <= '0;
      r_date  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_year  <= {1'b0, in_year};
          r_day   <= {1'b0, in_jday[FRAC_W+8:FRAC_W]};
          r_frac  <= in_jday[FRAC_W-1:0];
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_hour  <= w_carry ? 5'd0 : w_hr;
          r_day   <= w_wrap ? 10'd1 : w_d1;
          r_year  <= w_year2;
          r_m     <= 4'd1;
          r_err   <= w_err;
          r_date  <= w_err ? 32'd0 : r_date;
          r_state <= w_err ? S_DONE : S_MONTH;
        end
        S_MONTH: if (r_day <= {5'd0, w_len}) r_state <= S_PACK;
        else begin
          r_day <= r_day - {5'd0, w_len};
          r_m   <= r_m + 4'd1;
        end
        S_PACK: begin
          r_date  <= w_pack;
          r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/day_to_date_enc.md
Name: day_to_date_enc

Overview:
Sequential encoder that converts a (year, fractional julian day) pair back into the packed integer date YYYYMMDDHH used by the storm track files. It is the inverse of the date-to-day conversion in the parametric storm-stats path. It sits between the track time interpolator (producing julian-day times) and the track/output writer (needing packed dates). It uses a valid/ready handshake on both sides and an iterative month search, one month per cycle.

Parameters:
FRAC_W, 8, fraction bits of julday input (julday = integer day + frac/2^FRAC_W)
YEAR_W, 12, width of year input; valid years 0..2147 (packed result must fit signed 32-bit)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept request
in_year  in  YEAR_W  calendar year
in_jday  in  9+FRAC_W  unsigned fixed point; [FRAC_W+8:FRAC_W] day-of-year, [FRAC_W-1:0] fraction of day
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_date  out  32  packed YYYYMMDDHH = year*1000000+month*10000+day*100+hour
out_err  out  1  request invalid; out_date forced 0

Behaviour:
- One clock; reset is asynchronous and active-high. Reset values: state IDLE, in_ready=1, out_valid=0, out_date=0, out_err=0, all internal registers 0.
- States: IDLE, ROUND, MONTH, PACK, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid&&in_ready, capture year, day D, fraction F. Next state is ROUND.
- ROUND:
  - hour = (F*24 + 2^(FRAC_W-1)) >> FRAC_W, rounded to nearest.
  - If hour==24: hour=0, D=D+1.
  - If D then exceeds the year length: year=year+1, D=1.
  - Error if original D==0, original D>yearlen(year), or final year>2147. On error, set out_err=1 and out_date=0, then go to DONE.
  - Otherwise go to MONTH with m=1.
- MONTH: each cycle, if D<=len(m,year), go to PACK. Else D=D-len(m) and m=m+1. m never exceeds 12 for valid input.
- Month lengths are 31,28,31,30,31,30,31,31,30,31,30,31; Feb=29 when leap.
- Leap rule (default): year mod 4 == 0.
- PACK: out_date = year*1000000 + m*10000 + D*100 + hour. Use constant multiplies or a shift-add network; no truncation, since the result is at most 2147123123. Go to DONE.
- DONE: out_valid=1 and out_date/out_err are held stable until out_ready=1. On that edge, out_valid=0 and the block returns to IDLE. No new accept occurs on that same edge.
- Latency, counting the accepting edge as 0:
  - Valid request: out_valid rises after edge M+2, where M is the resulting month.
  - Error: out_valid rises after edge 1.
- Throughput is one request in flight at a time.
- rst asserted mid-operation aborts the request immediately. No partial result is emitted.

Optional Feature:
DAY_TO_DATE_LEAP400_EN
- Defined: full Gregorian leap rule, leap = (y%4==0) && !(y%100==0 && y%400!=0). Non-leap centuries 100..2100 are decoded by a constant compare list (no divider).
- Not defined: leap = y%4==0 only, matching the existing date-to-day conversion so that round trips are exact.

Test Plan:
- Leap date: year=2024, jday=60.0 (frac 0) -> out_date=2024022900, out_err=0, out_valid after edge 4.
- Non-leap date: year=2023, jday=60.0 -> 2023030100, latency 5.
- Midday rounding: year=2023, jday=1+0x80/256 -> hour 12 -> 2023010112, latency 3.
- Year-end carry: year=2023, jday=365+0xFF/256 -> hour rounds to 24 -> 2024010100.
- Errors, each giving out_err=1, out_date=0, latency 1:
  - jday=0
  - year=2023, jday=366
  - year=2147, jday=365+0xFF/256 (carry overflow)
- Backpressure/reset/feature:
  - Hold out_ready=0 for 10 cycles: out_valid and out_date stay stable and in_ready stays 0.
  - rst pulse during MONTH: outputs return to reset values asynchronously.
  - year=2100, jday=60: 2100022900 without DAY_TO_DATE_LEAP400_EN; 2100030100 with it.
